// File: rtl/dual_port_ram_ctrl.sv
// dual_port_ram_ctrl
//   Initiator side of a dual-port RAM interface. Two clients (A, B) issue
//   valid/ready read/write requests; accepted requests are registered onto the
//   RAM port pins and answered exactly two cycles later with the RAM's
//   read-before-write data. Same-address hazards (both valid, same address,
//   at least one write) are resolved so the RAM never sees a conflicting pair:
//   B normally yields, but after STALL_MAX consecutive lost conflicts B wins one.
//
// Ports
//   clk, rst                      clock (posedge), synchronous active-high reset
//   req_{a,b}_valid/ready         request handshake (ready is combinational)
//   req_{a,b}_we/addr/wdata       request kind, address, write data
//   rsp_{a,b}_valid/rdata         response strobe and data (latency 2, no stall)
//   ram_{addr,din,we}_{a,b}       registered RAM port pins
//   ram_dout_{a,b}                RAM read data (valid the cycle after sampling)
//   conflict_cnt                  saturating count of conflict cycles
module dual_port_ram_ctrl #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STALL_MAX = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  // Client A
  input  logic              req_a_valid,
  output logic              req_a_ready,
  input  logic              req_a_we,
  input  logic [ADDR_W-1:0] req_a_addr,
  input  logic [DATA_W-1:0] req_a_wdata,
  output logic              rsp_a_valid,
  output logic [DATA_W-1:0] rsp_a_rdata,
  // Client B
  input  logic              req_b_valid,
  output logic              req_b_ready,
  input  logic              req_b_we,
  input  logic [ADDR_W-1:0] req_b_addr,
  input  logic [DATA_W-1:0] req_b_wdata,
  output logic              rsp_b_valid,
  output logic [DATA_W-1:0] rsp_b_rdata,
  // RAM pins
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_din_a,
  output logic [DATA_W-1:0] ram_din_b,
  output logic              ram_we_a,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_dout_a,
  input  logic [DATA_W-1:0] ram_dout_b,
  // Statistics
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int unsigned StallW = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
  localparam logic [StallW-1:0] StallMax = StallW'(STALL_MAX);

  // State
  logic [StallW-1:0] stall_q, stall_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;
  logic [ADDR_W-1:0] ram_addr_a_q, ram_addr_b_q;
  logic [DATA_W-1:0] ram_din_a_q, ram_din_b_q;
  logic              ram_we_a_q, ram_we_b_q;
  // pend_* marks a request sitting on the RAM pins this cycle
  logic              pend_a_q, pend_b_q;
  logic              rsp_a_valid_q, rsp_b_valid_q;

  logic conflict, b_starved, acc_a, acc_b;

  // Arbitration
  always_comb begin
    conflict    = req_a_valid && req_b_valid && (req_a_addr == req_b_addr) &&
                  (req_a_we || req_b_we);
    b_starved   = (stall_q == StallMax);
    req_a_ready = !(conflict && b_starved);
    req_b_ready = !(conflict && !b_starved);
    acc_a       = req_a_valid && req_a_ready;
    acc_b       = req_b_valid && req_b_ready;
  end

  // Starvation and statistics counters
  always_comb begin
    stall_d = stall_q;
    if (conflict && !b_starved) begin
      stall_d = stall_q + StallW'(1);
    end else if (acc_b) begin
      // Covers both a normal accept and a win by starvation
      stall_d = '0;
    end

    conflict_cnt_d = conflict_cnt_q;
    if (conflict && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q        <= '0;
      conflict_cnt_q <= '0;
    end else begin
      stall_q        <= stall_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // RAM pin registers and response pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr_a_q  <= '0;
      ram_addr_b_q  <= '0;
      ram_din_a_q   <= '0;
      ram_din_b_q   <= '0;
      ram_we_a_q    <= 1'b0;
      ram_we_b_q    <= 1'b0;
      pend_a_q      <= 1'b0;
      pend_b_q      <= 1'b0;
      rsp_a_valid_q <= 1'b0;
      rsp_b_valid_q <= 1'b0;
    end else begin
      // Write enable is a one-cycle pulse; addr/din hold when idle
      ram_we_a_q <= acc_a && req_a_we;
      ram_we_b_q <= acc_b && req_b_we;
      if (acc_a) begin
        ram_addr_a_q <= req_a_addr;
        ram_din_a_q  <= req_a_wdata;
      end
      if (acc_b) begin
        ram_addr_b_q <= req_b_addr;
        ram_din_b_q  <= req_b_wdata;
      end
      pend_a_q      <= acc_a;
      pend_b_q      <= acc_b;
      rsp_a_valid_q <= pend_a_q;
      rsp_b_valid_q <= pend_b_q;
    end
  end

  // Outputs
  always_comb begin
    ram_addr_a   = ram_addr_a_q;
    ram_addr_b   = ram_addr_b_q;
    ram_din_a    = ram_din_a_q;
    ram_din_b    = ram_din_b_q;
    ram_we_a     = ram_we_a_q;
    ram_we_b     = ram_we_b_q;
    rsp_a_valid  = rsp_a_valid_q;
    rsp_b_valid  = rsp_b_valid_q;
    // RAM output is only meaningful alongside the response strobe
    rsp_a_rdata  = rsp_a_valid_q ? ram_dout_a : '0;
    rsp_b_rdata  = rsp_b_valid_q ? ram_dout_b : '0;
    conflict_cnt = conflict_cnt_q;
  end

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Bench for dual_port_ram_ctrl: directed scenarios followed by random traffic,
// checked against a transaction-level model (golden memory + response queues).
module tb_dual_port_ram_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned SM = 3;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a_valid, req_a_ready, req_a_we;
  logic [AW-1:0] req_a_addr;
  logic [DW-1:0] req_a_wdata;
  logic          rsp_a_valid;
  logic [DW-1:0] rsp_a_rdata;
  logic          req_b_valid, req_b_ready, req_b_we;
  logic [AW-1:0] req_b_addr;
  logic [DW-1:0] req_b_wdata;
  logic          rsp_b_valid;
  logic [DW-1:0] rsp_b_rdata;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a, ram_din_b;
  logic          ram_we_a, ram_we_b;
  logic [DW-1:0] ram_dout_a = '0;
  logic [DW-1:0] ram_dout_b = '0;
  logic [CW-1:0] conflict_cnt;

  always #5 clk = ~clk;

  dual_port_ram_ctrl #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .STALL_MAX(SM),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_a_valid (req_a_valid),
    .req_a_ready (req_a_ready),
    .req_a_we    (req_a_we),
    .req_a_addr  (req_a_addr),
    .req_a_wdata (req_a_wdata),
    .rsp_a_valid (rsp_a_valid),
    .rsp_a_rdata (rsp_a_rdata),
    .req_b_valid (req_b_valid),
    .req_b_ready (req_b_ready),
    .req_b_we    (req_b_we),
    .req_b_addr  (req_b_addr),
    .req_b_wdata (req_b_wdata),
    .rsp_b_valid (rsp_b_valid),
    .rsp_b_rdata (rsp_b_rdata),
    .ram_addr_a  (ram_addr_a),
    .ram_addr_b  (ram_addr_b),
    .ram_din_a   (ram_din_a),
    .ram_din_b   (ram_din_b),
    .ram_we_a    (ram_we_a),
    .ram_we_b    (ram_we_b),
    .ram_dout_a  (ram_dout_a),
    .ram_dout_b  (ram_dout_b),
    .conflict_cnt(conflict_cnt)
  );

  // Synchronous read-before-write RAM attached to the pins
  logic [DW-1:0] ram_mem [2**AW] = '{default: '0};
  always @(posedge clk) begin
    ram_dout_a <= ram_mem[ram_addr_a];
    ram_dout_b <= ram_mem[ram_addr_b];
    if (ram_we_a) ram_mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) ram_mem[ram_addr_b] <= ram_din_b;
  end

  // Reference model state
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  logic [DW-1:0] m_mem [2**AW] = '{default: '0};
  exp_t          qa[$];
  exp_t          qb[$];
  int            m_stall;
  int            m_conf;
  bit            m_after_rst;
  int            cyc;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: check outputs of this cycle, drive a request pair,
  // check ready, then advance the model past the coming edge.
  task automatic step(input bit r,
                      input bit va, input bit wa, input logic [AW-1:0] aa,
                      input logic [DW-1:0] da,
                      input bit vb, input bit wb, input logic [AW-1:0] ab,
                      input logic [DW-1:0] db);
    bit conf, bwin, ea, eb, acc_a, acc_b;
    exp_t e;
    @(negedge clk);
    if (m_after_rst) begin
      check("rst_ram_we_a", 32'(ram_we_a), 32'd0);
      check("rst_ram_we_b", 32'(ram_we_b), 32'd0);
      check("rst_ram_addr_a", 32'(ram_addr_a), 32'd0);
      check("rst_ram_addr_b", 32'(ram_addr_b), 32'd0);
      check("rst_ram_din_a", 32'(ram_din_a), 32'd0);
      check("rst_ram_din_b", 32'(ram_din_b), 32'd0);
    end
    if (qa.size() > 0 && qa[0].due == cyc) begin
      check("rsp_a_valid", 32'(rsp_a_valid), 32'd1);
      check("rsp_a_rdata", 32'(rsp_a_rdata), 32'(qa[0].data));
      void'(qa.pop_front());
    end else begin
      check("rsp_a_valid", 32'(rsp_a_valid), 32'd0);
      check("rsp_a_rdata", 32'(rsp_a_rdata), 32'd0);
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      check("rsp_b_valid", 32'(rsp_b_valid), 32'd1);
      check("rsp_b_rdata", 32'(rsp_b_rdata), 32'(qb[0].data));
      void'(qb.pop_front());
    end else begin
      check("rsp_b_valid", 32'(rsp_b_valid), 32'd0);
      check("rsp_b_rdata", 32'(rsp_b_rdata), 32'd0);
    end
    check("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));

    if (r) begin
      va = 1'b0;
      vb = 1'b0;
    end
    rst         = r;
    req_a_valid = va;
    req_a_we    = wa;
    req_a_addr  = aa;
    req_a_wdata = da;
    req_b_valid = vb;
    req_b_we    = wb;
    req_b_addr  = ab;
    req_b_wdata = db;
    #1;
    conf = va && vb && (aa == ab) && (wa || wb);
    bwin = (m_stall == SM);
    ea   = !(conf && bwin);
    eb   = !(conf && !bwin);
    check("req_a_ready", 32'(req_a_ready), 32'(ea));
    check("req_b_ready", 32'(req_b_ready), 32'(eb));

    if (r) begin
      qa.delete();
      qb.delete();
      m_stall     = 0;
      m_conf      = 0;
      m_after_rst = 1'b1;
    end else begin
      m_after_rst = 1'b0;
      acc_a = va && ea;
      acc_b = vb && eb;
      // Accepted pair never writes an address the other side touches
      if (acc_a) begin e.due = cyc + 2; e.data = m_mem[aa]; qa.push_back(e); end
      if (acc_b) begin e.due = cyc + 2; e.data = m_mem[ab]; qb.push_back(e); end
      if (acc_a && wa) m_mem[aa] = da;
      if (acc_b && wb) m_mem[ab] = db;
      if (conf && !bwin) m_stall++;
      else if (acc_b)    m_stall = 0;
      if (conf && m_conf != (2**CW - 1)) m_conf++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    rst = 1'b1;
    req_a_valid = 1'b0; req_a_we = 1'b0; req_a_addr = '0; req_a_wdata = '0;
    req_b_valid = 1'b0; req_b_we = 1'b0; req_b_addr = '0; req_b_wdata = '0;
    m_stall = 0; m_conf = 0; m_after_rst = 1'b1; cyc = 0;
    repeat (2) @(posedge clk);

    // Reset values, then write/read-back on A
    step(0, 1, 1, 4'd5, 8'hA5, 0, 0, '0, '0);
    step(0, 1, 0, 4'd5, 8'h00, 0, 0, '0, '0);
    idle(3);

    // A write vs B read same address: B yields, then reads new data
    step(0, 1, 1, 4'd3, 8'h11, 1, 0, 4'd3, 8'h00);
    step(0, 0, 0, 4'd0, 8'h00, 1, 0, 4'd3, 8'h00);
    idle(3);
    check("conflict_after_t3", 32'(conflict_cnt), 32'd1);

    // Read-read to the same address is never a conflict
    step(1, 0, 0, '0, '0, 0, 0, '0, '0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 4'd7, '0, 1, 0, 4'd7, '0);
    idle(3);
    check("conflict_after_t4", 32'(conflict_cnt), 32'd0);

    // Write-write same address: starvation pattern
    step(1, 0, 0, '0, '0, 0, 0, '0, '0);
    for (int i = 0; i < 10; i++)
      step(0, 1, 1, 4'd2, 8'(i), 1, 1, 4'd2, 8'(8'h80 + i));
    idle(3);

    // Reset with responses in flight
    step(0, 1, 0, 4'd5, '0, 1, 0, 4'd3, '0);
    step(1, 1, 0, 4'd5, '0, 1, 0, 4'd3, '0);
    idle(4);

    // Random traffic, addresses mostly confined to force hazards
    for (int i = 0; i < 1500; i++) begin
      bit narrow;
      narrow = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom),
           narrow ? 4'($urandom_range(0, 3)) : 4'($urandom),
           8'($urandom),
           $urandom_range(0, 3) != 0, 1'($urandom),
           narrow ? 4'($urandom_range(0, 3)) : 4'($urandom),
           8'($urandom));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
